// File: rtl/debouncer_pkg.sv
// Shared types and default constants for the input debouncer slice.
package debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Reusable multi-flop synchroniser with asynchronous active-low reset.
module bit_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw level one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces a raw bouncy level; optional edge strobes.
// Build option: DEBOUNCER_EDGE_PULSE_EN enables rise_pulse/fall_pulse,
// otherwise both are tied low and d_out timing is unchanged.
module input_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din_raw),
    .q  (s)
  );

  // Next-state logic: count agreeing samples, accept on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          d_out_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          d_out_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        d_out_d = 1'b0;
      end
    endcase
  end

  // FSM, counter and debounced output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes derive from the output transition so they coincide with d_out.
  always_comb begin
    rise_d = d_out_d & ~d_out_q;
    fall_d = ~d_out_d & d_out_q;
  end

  // Pulse registers; reset discards any pending strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_debouncer;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  typedef struct packed {
    logic d;
    logic r;
    logic f;
  } exp_t;

  logic clk;
  logic rst;
  logic din_raw;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_raw   (din_raw),
    .d_out     (d_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic push_exp(input logic d, input logic r, input logic f);
    exp_t e;
    e.d = d;
    e.r = r & PULSE_EN;
    e.f = f & PULSE_EN;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst     = 1'b0;
    din_raw = 1'b1;
    #1;
    checks++;
    if ({d_out, rise_pulse, fall_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async: got d/r/f=%b%b%b want 000", d_out, rise_pulse, fall_pulse);
    end
    for (int k = 1; k <= 5; k++) begin
      push_exp(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL reset_hold k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
    din_raw = 1'b0;
    rst     = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_exp(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL reset_release k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  // Stable 0->1: accepted on the 6th edge after the change.
  task automatic test_rise();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      din_raw = 1'b1;
      push_exp(k >= 6, k == 6, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL rise k=%0d: got d/r/f=%b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  // Stable 1->0: accepted on the 6th edge after the change.
  task automatic test_fall();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      din_raw = 1'b0;
      push_exp(k < 6, 1'b0, k == 6);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL fall k=%0d: got d/r/f=%b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  // Three high samples are one short of acceptance: no change.
  task automatic test_glitch();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      din_raw = (k <= 3);
      push_exp(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL glitch k=%0d: got d/r/f=%b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  // Exactly four high samples: accepted, then a clean return to low.
  task automatic test_boundary();
    exp_t e;
    for (int k = 1; k <= 14; k++) begin
      din_raw = (k <= 4);
      push_exp((k >= 6) && (k < 10), k == 6, k == 10);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL boundary k=%0d: got d/r/f=%b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  // Reset mid-wait: outputs clear at once, FSM restarts from ST_LOW.
  task automatic test_reset_mid_wait();
    exp_t e;
    for (int k = 1; k <= 4; k++) begin
      din_raw = 1'b1;
      push_exp(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL midwait_hi_pre k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({d_out, rise_pulse, fall_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL midwait_hi_rst: got d/r/f=%b%b%b want 000", d_out, rise_pulse, fall_pulse);
    end
    #4;
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din_raw = 1'b1;
      push_exp(k >= 6, k == 6, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL midwait_hi_post k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) begin
      din_raw = 1'b0;
      push_exp(1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL midwait_lo_pre k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({d_out, rise_pulse, fall_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL midwait_lo_rst: got d/r/f=%b%b%b want 000", d_out, rise_pulse, fall_pulse);
    end
    #4;
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      din_raw = 1'b0;
      push_exp(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({d_out, rise_pulse, fall_pulse} !== {e.d, e.r, e.f}) begin
        failures++;
        $display("FAIL midwait_lo_post k=%0d: got %b%b%b want %b%b%b", k, d_out, rise_pulse, fall_pulse, e.d, e.r, e.f);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_boundary();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
